fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core: owns the program counter, drives the instruction memory's address, and captures the asynchronously read instruction into the IF/ID pipeline register. Sits directly upstream of decode and directly drives the instruction memory. Handles hazard-unit stalls and EX-stage redirects, and optionally predicts the next PC with a small branch target buffer.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BTB_ENTRIES, 32, BTB depth; power of two, ≥2 (used only with BTB_EN)
- reset  in  1  synchronous, active-high reset
- clk  in  1  core clock, all state updates on rising edge
- imem_addr  out  32  byte address to instruction memory (equals current PC, combinational)
- imem_dout  in  32  instruction at imem_addr, valid in the same cycle
- stall  in  1  hold PC and IF/ID contents
- redirect  in  1  EX-resolved control transfer or misprediction; flush and jump
- redirect_pc  in  32  target PC for redirect
- upd_valid  in  1  BTB training strobe from EX (one per resolved branch/jump)
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual taken target
- id_valid  out  1  IF/ID holds a real instruction
- id_pc  out  32  PC of id_inst
- id_inst  out  32  fetched instruction (NOP when invalid)
- id_pred_taken  out  1  prediction made for id_inst
- id_pred_target  out  32  predicted next PC for id_inst

## Operation
- Next-PC priority, highest first: reset > redirect > stall > predicted next PC.
- reset: pc←RESET_PC; id_valid←0, id_pc←0, id_inst←NOP (32'h0000_0013), id_pred_taken←0, id_pred_target←0; BTB valid bits all cleared.
- redirect: pc←{redirect_pc[31:2],2'b00}; id_valid←0, id_inst←NOP, id_pred_taken←0; redirect overrides a simultaneous stall.
- stall (no redirect): pc and all id_* hold.
- normal: pc←pred_next; id_valid←1, id_pc←pc, id_inst←imem_dout, id_pred_taken/target←current prediction.
- pred_next = pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) unless BTB predicts taken, then BTB target.
- imem_addr = pc at all times, including during stall and reset cycles.

## Timing
- Fetch latency: instruction at PC p appears on id_* one edge after p is on imem_addr.
- Redirect at edge E: id_valid=0 after E; target instruction valid in IF/ID after E+1 (one bubble).
- Stall held N cycles: id_* unchanged for N cycles, no instruction lost or duplicated.
- BTB lookup combinational on pc; update written at edge. Same-cycle lookup and update to the same index: lookup sees old contents.
- Reset asserted mid-operation: takes effect at the next edge regardless of stall/redirect/upd_valid.

## Configuration
- FETCH_BTB_EN defined: direct-mapped BTB, BTB_ENTRIES entries of {valid, tag, target, 2-bit counter}; index = pc[2+log2(N)-1:2], tag = remaining upper bits. Predict taken iff valid, tag match, counter ≥ 2.
  - Update, entry hit: counter saturating ±1 by upd_taken; target overwritten when upd_taken.
  - Update, miss/invalid: allocate only if upd_taken (valid←1, tag, target, counter←2'b10); not-taken miss ignored.
- FETCH_BTB_EN undefined: no BTB storage; pred_next = pc+4, id_pred_taken=0, id_pred_target=pc+4; upd_* ignored.

## Structure
- Shared package: NOP encoding, default RESET_PC, counter encodings (strongly/weakly not-taken/taken).
- One sub-module: fetch_btb (lookup port + update port), instantiated only under FETCH_BTB_EN.

## Test plan
- Reset with RESET_PC=0, then 3 free-running cycles over imem words 0x0,0x4,0x8 → imem_addr 0,4,8,12; id_pc 0,4,8 with id_valid=1 and matching id_inst.
- stall high 3 cycles at pc=0x10 → imem_addr stays 0x10, id_* frozen; release → id_pc=0x10 next edge, no skip or duplicate.
- redirect to 0x40 with simultaneous stall → pc=0x40, id_valid=0, id_inst=0x00000013; next edge id_pc=0x40, id_valid=1.
- FETCH_BTB_EN: upd taken pc=0x20 target=0x80 → next fetch of 0x20 yields id_pred_taken=1, imem_addr=0x80 following; two not-taken updates → prediction returns to pc+4.
- pc=0xFFFF_FFFC, no BTB hit → next imem_addr=0x0000_0000.
- reset asserted during redirect and upd_valid → all outputs at reset values, BTB predicts not-taken for previously trained PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, reset PC,
// BTB counter encodings and the BTB training request.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } btb_ctr_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } btb_upd_t;

    // Saturating two-bit step toward the resolved outcome.
    function automatic btb_ctr_e ctr_step(input btb_ctr_e ctr, input logic taken);
        btb_ctr_e nxt;
        nxt = ctr;
        case (ctr)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_SNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_stage_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// training written at the clock edge (a same-cycle lookup sees old contents).
module fetch_btb
    import fetch_stage_pkg::*;
#(
    parameter int ENTRIES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  btb_upd_t    upd
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:2]      target;
        btb_ctr_e         ctr;
    } entry_t;

    entry_t [ENTRIES-1:0] ents;

    logic [IDX_W-1:0] lidx, uidx;
    logic [TAG_W-1:0] ltag, utag;

    assign lidx = lookup_pc[IDX_W+1:2];
    assign ltag = lookup_pc[31:IDX_W+2];
    assign uidx = upd.pc[IDX_W+1:2];
    assign utag = upd.pc[31:IDX_W+2];

    genvar i;
    generate
        for (i = 0; i < ENTRIES; i++) begin : g_entry
            entry_t ent_q;
            logic   sel, hit;

            assign sel     = upd.valid && (uidx == IDX_W'(i));
            assign hit     = ent_q.valid && (ent_q.tag == utag);
            assign ents[i] = ent_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    ent_q.valid <= 1'b0;
                end else if (sel) begin
                    if (hit) begin
                        ent_q.ctr <= ctr_step(ent_q.ctr, upd.taken);
                        if (upd.taken)
                            ent_q.target <= upd.target[31:2];
                    end else if (upd.taken) begin
                        // Not-taken misses never allocate.
                        ent_q.valid  <= 1'b1;
                        ent_q.tag    <= utag;
                        ent_q.target <= upd.target[31:2];
                        ent_q.ctr    <= CTR_WT;
                    end
                end
            end
        end
    endgenerate

    entry_t lent;
    assign lent        = ents[lidx];
    assign pred_taken  = lent.valid && (lent.tag == ltag) && lent.ctr[1];
    assign pred_target = {lent.target, 2'b00};

    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], upd.pc[1:0], upd.target[1:0]};

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and next-PC
// selection. Define FETCH_BTB_EN to add branch-target-buffer prediction.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          BTB_ENTRIES = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_pred_taken,
    output logic [31:0] id_pred_target
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] pred_next;
    btb_upd_t    upd;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    assign upd.valid  = upd_valid;
    assign upd.pc     = upd_pc;
    assign upd.taken  = upd_taken;
    assign upd.target = upd_target;

`ifdef FETCH_BTB_EN
    logic [31:0] btb_target;

    fetch_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk         (clk),
        .reset       (reset),
        .lookup_pc   (pc),
        .pred_taken  (pred_taken),
        .pred_target (btb_target),
        .upd         (upd)
    );

    assign pred_target = pred_taken ? btb_target : pc_plus4;
`else
    logic unused_upd;
    assign unused_upd  = ^upd;
    assign pred_taken  = 1'b0;
    assign pred_target = pc_plus4;
`endif

    assign pred_next = pred_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            id_valid       <= 1'b0;
            id_pc          <= 32'h0;
            id_inst        <= NOP_INST;
            id_pred_taken  <= 1'b0;
            id_pred_target <= 32'h0;
        end else if (redirect) begin
            // Redirect wins over stall; the IF/ID slot becomes a bubble.
            pc            <= {redirect_pc[31:2], 2'b00};
            id_valid      <= 1'b0;
            id_inst       <= NOP_INST;
            id_pred_taken <= 1'b0;
        end else if (!stall) begin
            pc             <= pred_next;
            id_valid       <= 1'b1;
            id_pc          <= pc;
            id_inst        <= imem_dout;
            id_pred_taken  <= pred_taken;
            id_pred_target <= pred_target;
        end
    end

endmodule
